// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter.
// Optional even parity is enabled by defining UART_TX_PARITY_EN.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  // 100 MHz system clock / 115200 baud
  localparam int unsigned DEFAULT_CLK_DIV = 868;

`ifdef UART_TX_PARITY_EN
  localparam int unsigned FRAME_BITS = 11;
`else
  localparam int unsigned FRAME_BITS = 10;
`endif

endpackage

// File: rtl/uart_tx_fifo.sv
// 8-bit synchronous FIFO with full/empty flags; pushes while full and pops
// while empty are dropped. Head data is presented combinationally on rd_data.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;

  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // DEPTH is a power of two, so pointer overflow is the modulo wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx.sv
// Buffered UART transmitter, 8 data bits LSB first, one stop bit.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV    = DEFAULT_CLK_DIV,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       UART_RXD_OUT
);

  localparam int unsigned TW = $clog2(CLK_DIV + 1);
  localparam logic [TW-1:0] RELOAD = TW'(CLK_DIV - 1);

  uart_state_t   state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          line_q, line_d;
`ifdef UART_TX_PARITY_EN
  logic          parity_q, parity_d;
`endif

  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_pop;
  logic [7:0] fifo_rd_data;

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (tx_valid),
    .wr_data (tx_data),
    .full    (fifo_full),
    .rd_en   (fifo_pop),
    .rd_data (fifo_rd_data),
    .empty   (fifo_empty)
  );

  assign tx_ready     = !fifo_full;
  assign tx_busy      = (state_q != IDLE) || !fifo_empty;
  assign UART_RXD_OUT = line_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      line_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      line_q    <= line_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    line_d    = line_q;
    fifo_pop  = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    // Mid-bit: just count down; every branch below is a bit boundary
    if (state_q != IDLE && timer_q != '0) begin
      timer_d = timer_q - 1'b1;
    end else begin
      case (state_q)
        IDLE, STOP: begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rd_data;
            line_d   = 1'b0;
            timer_d  = RELOAD;
            state_d  = START;
`ifdef UART_TX_PARITY_EN
            parity_d = ^fifo_rd_data;
`endif
          end else begin
            line_d  = 1'b1;
            timer_d = '0;
            state_d = IDLE;
          end
        end
        START: begin
          line_d    = shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = '0;
          timer_d   = RELOAD;
          state_d   = DATA;
        end
        DATA: begin
          timer_d = RELOAD;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            line_d  = parity_q;
            state_d = PARITY;
`else
            line_d  = 1'b1;
            state_d = STOP;
`endif
          end else begin
            line_d    = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
        PARITY: begin
          line_d  = 1'b1;
          timer_d = RELOAD;
          state_d = STOP;
        end
        default: begin
          line_d  = 1'b1;
          timer_d = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLK_DIV, default 868, SHALL set clk cycles per bit (100 MHz / 115200 baud).
REQ-002 Parameter FIFO_DEPTH, default 4 (power of two, min 2), SHALL set the transmit buffer depth in bytes.
REQ-003 Port clk, input, 1 bit: 100 MHz system clock; the block SHALL use this single clock with all logic on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, SHALL be asynchronous and active-low.
REQ-005 Port tx_data, input, 8 bits: byte to send.
REQ-006 Port tx_valid, input, 1 bit: tx_data is valid.
REQ-007 Port tx_ready, output, 1 bit: buffer can accept a byte.
REQ-008 Port tx_busy, output, 1 bit: frame in progress or buffer non-empty.
REQ-009 Port UART_RXD_OUT, output, 1 bit: serial line to the host, idle high.

Function
REQ-010 A byte SHALL be accepted on a rising edge where tx_valid and tx_ready are both 1; tx_data SHALL be sampled on that edge only.
REQ-011 tx_ready SHALL equal NOT full and SHALL NOT depend on a same-cycle pop; a push while full SHALL be ignored, with no overwrite.
REQ-012 The buffer SHALL be FIFO-ordered; read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-013 The FSM SHALL use states IDLE, START, DATA, PARITY, STOP.
REQ-014 IDLE: if the FIFO is non-empty, the FSM SHALL pop the head, load the shift register, drive the line 0 and enter START on the same edge.
REQ-015 Given REQ-014, the line SHALL fall at the first rising edge after the accepting edge when the FIFO was empty and the FSM was in IDLE.
REQ-016 Each bit SHALL last exactly CLK_DIV cycles, counted by a bit-timer that reloads at every bit boundary.
REQ-017 START to DATA: the FSM SHALL send 8 data bits, LSB first.
REQ-018 DATA: after bit 7 the FSM SHALL go to PARITY if enabled (REQ-026), otherwise to STOP.
REQ-019 STOP SHALL drive 1 for one bit time.
REQ-020 At the end of STOP, a non-empty FIFO SHALL start the next frame with its start bit on the same edge (no idle gap); an empty FIFO SHALL return the FSM to IDLE.
REQ-021 A push and a pop on the same edge SHALL both take effect; the occupancy count SHALL be unchanged.
REQ-022 tx_busy SHALL be 1 whenever the FSM is not in IDLE or the FIFO is non-empty.
REQ-023 UART_RXD_OUT SHALL be driven directly from a flop (glitch-free).

Reset
REQ-024 While rst_n=0, the block SHALL hold: UART_RXD_OUT=1, tx_ready=1, tx_busy=0, FSM=IDLE, FIFO empty, bit-timer=0.
REQ-025 Reset asserted mid-frame SHALL abort the frame at once, drive the line high and discard buffered bytes; after rst_n rises, the first transmission SHALL start only on a new push.

Configuration
REQ-026 With macro UART_TX_PARITY_EN defined, the block SHALL send an even-parity bit (XOR of the 8 data bits) in state PARITY between DATA and STOP, for an 11-bit frame; without it, PARITY SHALL be unreachable and frames SHALL be 10 bits (8N1).

Structure
REQ-027 Package uart_pkg SHALL hold the FSM state enum, the default CLK_DIV constant and the frame bit count constant.
REQ-028 The buffer SHALL be the sub-module uart_tx_fifo (8-bit synchronous FIFO with full/empty flags and asynchronous active-low reset); the FSM, bit-timer and shift register SHALL live in uart_tx.

Verification
REQ-029 Push 0xA5 after reset, 8N1: the line SHALL show 0,1,0,1,0,0,1,0,1,1, each for 868 cycles, with the start edge 1 cycle after acceptance.
REQ-030 With UART_TX_PARITY_EN, push 0xA5: the parity bit SHALL be 0; push 0x01: the parity bit SHALL be 1; total frame length SHALL be 11×868 cycles.
REQ-031 Hold tx_valid high with 0x00..0x05: tx_ready SHALL drop after 5 accepts (4 buffered + 1 popped); all 6 bytes SHALL go out in order, back-to-back, with no idle gap.
REQ-032 Push while full: the rejected byte SHALL never appear on the line; push and pop on the same edge when one byte is stored: count SHALL stay 1.
REQ-033 Assert rst_n low in DATA bit 3 of 0x3C with 2 bytes queued: the line SHALL go 1 within the same cycle; tx_busy=0; no output after release until a new push.
REQ-034 CLK_DIV=4 with 0xFF: each bit SHALL be 4 cycles; tx_busy SHALL fall exactly 40 cycles after the start edge.
